// File: rtl/uart_rx_sha_block_if.sv
// Bus bundle for the UART receiver / SHA-256 block assembler.
// The master side is the receiver, which produces the padded block and the
// per-byte status pulses. The slave side is the consumer, which drives the
// serial line and acknowledges finished blocks.
interface uart_rx_sha_block_if;
  logic         rx;
  logic [0:511] msg;
  logic         msg_valid;
  logic         msg_ack;
  logic [7:0]   byte_data;
  logic         byte_valid;
  logic         frame_err;
  logic         overflow;

  modport master (
    input  rx,
    input  msg_ack,
    output msg,
    output msg_valid,
    output byte_data,
    output byte_valid,
    output frame_err,
    output overflow
  );

  modport slave (
    output rx,
    output msg_ack,
    input  msg,
    input  msg_valid,
    input  byte_data,
    input  byte_valid,
    input  frame_err,
    input  overflow
  );
endinterface

// File: rtl/uart_rx_sha_block.sv
// 8N1 UART receiver that assembles a line of text into one SHA-256 padded
// 512-bit message block (big-endian, msg[0] is the MSB of the first byte).
// A line feed finalises the block, carriage returns are skipped, and the
// finished block is held until the consumer acknowledges it.
module uart_rx_sha_block #(
  parameter int CLKS_PER_BIT = 521
) (
  input  logic                clk,
  input  logic                reset,
  uart_rx_sha_block_if.master bus
);

  // Largest message that still leaves room for the pad byte and the
  // 64-bit length field inside a single 512-bit block.
  localparam int MAX_LEN = 55;

  localparam int                 TIMER_W = $clog2(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] HALF    = TIMER_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [TIMER_W-1:0] LAST    = TIMER_W'(CLKS_PER_BIT - 1);

  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam logic [5:0] LEN_FULL = 6'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // Synchroniser and receive datapath
  logic               rx_meta;
  logic               rs;
  rx_state_t          state;
  rx_state_t          state_nxt;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_nxt;
  logic [2:0]         bit_idx;
  logic [2:0]         bit_idx_nxt;
  logic [7:0]         shreg;
  logic [7:0]         shreg_nxt;
  logic               accept;
  logic               stop_bad;

  // Registered outputs and assembler state
  logic [0:511]       msg;
  logic               msg_valid;
  logic [7:0]         byte_data;
  logic               byte_valid;
  logic               frame_err;
  logic               overflow;
  logic [5:0]         len;
  logic [8:0]         wr_ptr;

  assign wr_ptr = {len, 3'b000};

  assign bus.msg        = msg;
  assign bus.msg_valid  = msg_valid;
  assign bus.byte_data  = byte_data;
  assign bus.byte_valid = byte_valid;
  assign bus.frame_err  = frame_err;
  assign bus.overflow   = overflow;

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rs      <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rs      <= rx_meta;
    end
  end

  // Receive FSM state, bit timer, bit index and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  // Next-state logic: start bit is qualified at mid-bit, then every data and
  // stop bit is sampled one full bit period later, i.e. also near mid-bit.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    accept      = 1'b0;
    stop_bad    = 1'b0;

    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (!rs) begin
          state_nxt = START;
        end
      end

      START: begin
        if (timer == HALF) begin
          timer_nxt = '0;
          if (!rs) begin
            state_nxt   = DATA;
            bit_idx_nxt = 3'd0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      DATA: begin
        if (timer == LAST) begin
          timer_nxt = '0;
          shreg_nxt = {rs, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      STOP: begin
        if (timer == LAST) begin
          timer_nxt = '0;
          state_nxt = IDLE;
          if (rs) begin
            accept = 1'b1;
          end else begin
            stop_bad = 1'b1;
          end
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // Publish an accepted byte or a framing error for exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= accept;
      frame_err  <= stop_bad;
      if (accept) begin
        byte_data <= shreg;
      end
    end
  end

  // Block assembler: bytes are written straight into msg, which is kept zero
  // beyond the current length so finalising only adds the pad and length.
  always_ff @(posedge clk) begin
    if (reset) begin
      msg       <= '0;
      msg_valid <= 1'b0;
      overflow  <= 1'b0;
      len       <= '0;
    end else begin
      overflow <= 1'b0;

      if (msg_valid && bus.msg_ack) begin
        msg_valid <= 1'b0;
        msg       <= '0;
      end

      if (byte_valid) begin
        if (msg_valid) begin
          overflow <= 1'b1;
        end else if (byte_data == CHAR_CR) begin
          overflow <= 1'b0;
        end else if (byte_data == CHAR_LF) begin
          msg[wr_ptr +: 8] <= PAD_BYTE;
          msg[448 +: 64]   <= {55'd0, len, 3'b000};
          msg_valid        <= 1'b1;
          len              <= '0;
        end else if (len == LEN_FULL) begin
          overflow <= 1'b1;
        end else begin
          msg[wr_ptr +: 8] <= byte_data;
          len              <= len + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sha_block.sv
// Self-checking bench for uart_rx_sha_block: a fast instance (16 clocks per
// bit) exercises all features, a second instance runs at the real rate.
module tb_uart_rx_sha_block;

  localparam int CPB_A = 16;
  localparam int CPB_B = 521;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int failures = 0;

  int bv_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] rcv_q[$];
  bit term_pending = 1'b0;

  uart_rx_sha_block_if bus_a ();
  uart_rx_sha_block_if bus_b ();

  uart_rx_sha_block #(.CLKS_PER_BIT(CPB_A)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.master)
  );

  uart_rx_sha_block #(.CLKS_PER_BIT(CPB_B)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.master)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  // Pulse counters and byte log for the fast instance, plus the check that
  // msg_valid rises on the cycle right after a terminating line feed.
  always @(negedge clk) begin
    if (term_pending) begin
      checks++;
      if (bus_a.msg_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL lf_latency: msg_valid=%b required 1", bus_a.msg_valid);
      end
      term_pending = 1'b0;
    end
    if (bus_a.byte_valid === 1'b1) begin
      bv_cnt++;
      rcv_q.push_back(bus_a.byte_data);
      if (bus_a.byte_data == 8'h0A && bus_a.msg_valid === 1'b0) term_pending = 1'b1;
    end
    if (bus_a.frame_err === 1'b1) fe_cnt++;
    if (bus_a.overflow === 1'b1) ov_cnt++;
  end

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: message bytes (terminator excluded) to padded block.
  function automatic logic [0:511] model_block(input logic [7:0] q[$], output int drops);
    logic [0:511] blk;
    int n;
    blk   = '0;
    n     = 0;
    drops = 0;
    foreach (q[i]) begin
      if (q[i] == 8'h0D) continue;
      if (n == 55) begin
        drops++;
      end else begin
        blk[n*8 +: 8] = q[i];
        n++;
      end
    end
    blk[n*8 +: 8] = 8'h80;
    blk[448 +: 64] = 64'(n * 8);
    return blk;
  endfunction

  task automatic set_rx(input bit on_b, input logic v);
    if (on_b) bus_b.rx = v;
    else bus_a.rx = v;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop, input bit on_b);
    int cpb;
    cpb = on_b ? CPB_B : CPB_A;
    set_rx(on_b, 1'b0);
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(on_b, b[i]);
      repeat (cpb) @(negedge clk);
    end
    if (good_stop) begin
      set_rx(on_b, 1'b1);
      repeat (cpb) @(negedge clk);
    end else begin
      set_rx(on_b, 1'b0);
      repeat (cpb / 2 + 4) @(negedge clk);
      set_rx(on_b, 1'b1);
      repeat (cpb * 2) @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic send_seq(input logic [7:0] q[$], input bit on_b);
    foreach (q[i]) send_byte(q[i], 1'b1, on_b);
  endtask

  task automatic wait_valid(input bit on_b, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((on_b ? bus_b.msg_valid : bus_a.msg_valid) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_ack(input bit on_b);
    @(negedge clk);
    if (on_b) bus_b.msg_ack = 1'b1;
    else bus_a.msg_ack = 1'b1;
    @(negedge clk);
    bus_a.msg_ack = 1'b0;
    bus_b.msg_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int bv0, fe0, ov0;
    do_reset();
    bv0 = bv_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    repeat (1000) @(negedge clk);
    checks++;
    if (bus_a.msg !== '0) begin
      failures++; $display("[TB] FAIL reset_msg: got %h required 0", bus_a.msg);
    end
    checks++;
    if ({bus_a.msg_valid, bus_a.byte_valid, bus_a.frame_err, bus_a.overflow} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b required 0000",
               {bus_a.msg_valid, bus_a.byte_valid, bus_a.frame_err, bus_a.overflow});
    end
    checks++;
    if (bus_a.byte_data !== 8'h00) begin
      failures++; $display("[TB] FAIL reset_byte_data: got %h required 00", bus_a.byte_data);
    end
    checks++;
    if ((bv_cnt - bv0) + (fe_cnt - fe0) + (ov_cnt - ov0) != 0) begin
      failures++;
      $display("[TB] FAIL idle_pulses: got %0d required 0", (bv_cnt - bv0) + (fe_cnt - fe0) + (ov_cnt - ov0));
    end
    checks++;
    if (bus_b.msg_valid !== 1'b0 || bus_b.msg !== '0) begin
      failures++; $display("[TB] FAIL reset_b: got valid=%b required 0", bus_b.msg_valid);
    end
  endtask

  task automatic test_abc();
    logic [7:0] q[$];
    logic [0:511] exp_blk;
    int drops, bv0, low_cycles, bad;
    bit ok;
    q = '{8'h61, 8'h62, 8'h63, 8'h0D, 8'h0A};
    rcv_q.delete();
    bv0 = bv_cnt;
    send_seq(q, 1'b0);
    wait_valid(1'b0, 200, ok);
    checks++;
    if (!ok) begin
      failures++; $display("[TB] FAIL abc_valid_timeout: got 0 required 1");
    end
    checks++;
    if (bus_a.msg[0:31] !== 32'h61626380) begin
      failures++; $display("[TB] FAIL abc_head: got %h required 61626380", bus_a.msg[0:31]);
    end
    checks++;
    if (bus_a.msg[32:447] !== '0) begin
      failures++; $display("[TB] FAIL abc_zero: got %h required 0", bus_a.msg[32:447]);
    end
    checks++;
    if (bus_a.msg[448:511] !== 64'h18) begin
      failures++; $display("[TB] FAIL abc_len: got %h required 18", bus_a.msg[448:511]);
    end
    exp_blk = model_block(q[0:3], drops);
    checks++;
    if (bus_a.msg !== exp_blk) begin
      failures++; $display("[TB] FAIL abc_model: got %h required %h", bus_a.msg, exp_blk);
    end
    low_cycles = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus_a.msg_valid !== 1'b1) low_cycles++;
    end
    checks++;
    if (low_cycles != 0) begin
      failures++; $display("[TB] FAIL abc_hold: got %0d low cycles required 0", low_cycles);
    end
    do_ack(1'b0);
    checks++;
    if (bus_a.msg_valid !== 1'b0 || bus_a.msg !== '0) begin
      failures++; $display("[TB] FAIL abc_ack: got valid=%b msg=%h required 0", bus_a.msg_valid, bus_a.msg);
    end
    checks++;
    if (bv_cnt - bv0 != 5) begin
      failures++; $display("[TB] FAIL abc_byte_valid: got %0d required 5", bv_cnt - bv0);
    end
    bad = 0;
    if (rcv_q.size() != q.size()) bad = 1;
    else foreach (q[i]) if (rcv_q[i] !== q[i]) bad = 1;
    checks++;
    if (bad != 0) begin
      failures++; $display("[TB] FAIL abc_byte_data: got %p required %p", rcv_q, q);
    end
  endtask

  task automatic test_empty_overflow();
    logic [7:0] q[$];
    logic [0:511] exp_blk;
    int ov0, bv0;
    bit ok;
    exp_blk = '0;
    exp_blk[0:7] = 8'h80;
    q = '{8'h0A};
    send_seq(q, 1'b0);
    wait_valid(1'b0, 200, ok);
    checks++;
    if (!ok || bus_a.msg !== exp_blk) begin
      failures++; $display("[TB] FAIL empty_block: got valid=%b msg=%h required %h", ok, bus_a.msg, exp_blk);
    end
    ov0 = ov_cnt; bv0 = bv_cnt;
    send_byte(8'h78, 1'b1, 1'b0);
    checks++;
    if (ov_cnt - ov0 != 1 || bv_cnt - bv0 != 1) begin
      failures++;
      $display("[TB] FAIL pending_overflow: got ov=%0d bv=%0d required 1 1", ov_cnt - ov0, bv_cnt - bv0);
    end
    checks++;
    if (bus_a.msg_valid !== 1'b1 || bus_a.msg !== exp_blk) begin
      failures++; $display("[TB] FAIL pending_hold: got valid=%b msg=%h required %h", bus_a.msg_valid, bus_a.msg, exp_blk);
    end
    do_ack(1'b0);
  endtask

  task automatic test_long();
    logic [7:0] q[$];
    logic [0:511] exp_blk;
    int drops, ov0;
    bit ok;
    for (int i = 0; i < 56; i++) q.push_back(8'h61);
    exp_blk = model_block(q, drops);
    ov0 = ov_cnt;
    send_seq(q, 1'b0);
    send_byte(8'h0A, 1'b1, 1'b0);
    wait_valid(1'b0, 200, ok);
    checks++;
    if (ov_cnt - ov0 != 1) begin
      failures++; $display("[TB] FAIL long_overflow: got %0d required 1", ov_cnt - ov0);
    end
    checks++;
    if (!ok || bus_a.msg[440:447] !== 8'h80 || bus_a.msg[448:511] !== 64'h1B8) begin
      failures++;
      $display("[TB] FAIL long_tail: got valid=%b pad=%h len=%h required 1 80 1b8", ok, bus_a.msg[440:447], bus_a.msg[448:511]);
    end
    checks++;
    if (bus_a.msg !== exp_blk) begin
      failures++; $display("[TB] FAIL long_model: got %h required %h", bus_a.msg, exp_blk);
    end
    do_ack(1'b0);
  endtask

  task automatic test_frame_err();
    logic [7:0] q[$];
    logic [0:511] exp_blk;
    int drops, fe0, bv0, ov0;
    bit ok;
    send_byte(8'h71, 1'b1, 1'b0);
    fe0 = fe_cnt; bv0 = bv_cnt;
    send_byte(8'h41, 1'b0, 1'b0);
    checks++;
    if (fe_cnt - fe0 != 1 || bv_cnt - bv0 != 0) begin
      failures++;
      $display("[TB] FAIL frame_err: got fe=%0d bv=%0d required 1 0", fe_cnt - fe0, bv_cnt - bv0);
    end
    fe0 = fe_cnt; bv0 = bv_cnt; ov0 = ov_cnt;
    bus_a.rx = 1'b0;
    repeat (3) @(negedge clk);
    bus_a.rx = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if ((fe_cnt - fe0) + (bv_cnt - bv0) + (ov_cnt - ov0) != 0) begin
      failures++;
      $display("[TB] FAIL glitch: got %0d pulses required 0", (fe_cnt - fe0) + (bv_cnt - bv0) + (ov_cnt - ov0));
    end
    q = '{8'h71};
    exp_blk = model_block(q, drops);
    send_byte(8'h0A, 1'b1, 1'b0);
    wait_valid(1'b0, 200, ok);
    checks++;
    if (!ok || bus_a.msg !== exp_blk) begin
      failures++; $display("[TB] FAIL frame_len_kept: got %h required %h", bus_a.msg, exp_blk);
    end
    do_ack(1'b0);
  endtask

  task automatic test_reset_midbyte();
    logic [7:0] q[$];
    logic [0:511] exp_blk;
    int drops;
    bit ok;
    q = '{8'h61, 8'h62};
    send_seq(q, 1'b0);
    bus_a.rx = 1'b0;
    repeat (CPB_A) @(negedge clk);
    bus_a.rx = 1'b1;
    repeat (CPB_A * 2) @(negedge clk);
    bus_a.rx = 1'b0;
    repeat (CPB_A / 2) @(negedge clk);
    bus_a.rx = 1'b1;
    do_reset();
    checks++;
    if (bus_a.msg_valid !== 1'b0 || bus_a.msg !== '0) begin
      failures++; $display("[TB] FAIL midreset_clear: got valid=%b msg=%h required 0", bus_a.msg_valid, bus_a.msg);
    end
    repeat (40) @(negedge clk);
    q = '{8'h63, 8'h0A};
    send_seq(q, 1'b0);
    wait_valid(1'b0, 200, ok);
    checks++;
    if (!ok || bus_a.msg[0:15] !== 16'h6380 || bus_a.msg[448:511] !== 64'h8) begin
      failures++;
      $display("[TB] FAIL midreset_block: got head=%h len=%h required 6380 8", bus_a.msg[0:15], bus_a.msg[448:511]);
    end
    q = '{8'h63};
    exp_blk = model_block(q, drops);
    checks++;
    if (bus_a.msg !== exp_blk) begin
      failures++; $display("[TB] FAIL midreset_model: got %h required %h", bus_a.msg, exp_blk);
    end
    do_ack(1'b0);
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [0:511] exp_blk;
    int drops, n, ov0, bv0;
    bit ok;
    for (int it = 0; it < 2; it++) begin
      q.delete();
      n = int'($urandom_range(0, 58));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 9) == 0) q.push_back(8'h0D);
        else q.push_back(8'($urandom_range(8'h20, 8'h7E)));
      end
      exp_blk = model_block(q, drops);
      ov0 = ov_cnt; bv0 = bv_cnt;
      send_seq(q, 1'b0);
      send_byte(8'h0A, 1'b1, 1'b0);
      wait_valid(1'b0, 200, ok);
      checks++;
      if (!ok || bus_a.msg !== exp_blk) begin
        failures++; $display("[TB] FAIL random_block%0d: got %h required %h", it, bus_a.msg, exp_blk);
      end
      checks++;
      if (ov_cnt - ov0 != drops || bv_cnt - bv0 != n + 1) begin
        failures++;
        $display("[TB] FAIL random_counts%0d: got ov=%0d bv=%0d required %0d %0d", it, ov_cnt - ov0, bv_cnt - bv0, drops, n + 1);
      end
      do_ack(1'b0);
    end
  endtask

  task automatic test_slow_rate();
    logic [7:0] q[$];
    bit ok;
    q = '{8'h61, 8'h62, 8'h63, 8'h0D, 8'h0A};
    send_seq(q, 1'b1);
    wait_valid(1'b1, 2000, ok);
    checks++;
    if (!ok || bus_b.msg[0:31] !== 32'h61626380 || bus_b.msg[32:447] !== '0 || bus_b.msg[448:511] !== 64'h18) begin
      failures++; $display("[TB] FAIL slow_abc: got valid=%b msg=%h required 61626380..18", ok, bus_b.msg);
    end
    do_ack(1'b1);
    checks++;
    if (bus_b.msg_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL slow_ack: got %b required 0", bus_b.msg_valid);
    end
  endtask

  // Test sequence
  initial begin
    bus_a.rx = 1'b1;
    bus_b.rx = 1'b1;
    bus_a.msg_ack = 1'b0;
    bus_b.msg_ack = 1'b0;
    test_reset();
    test_abc();
    test_empty_overflow();
    test_long();
    test_frame_err();
    test_reset_midbyte();
    test_random();
    test_slow_rate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
